// File: rtl/stack_engine.sv
// Stack/control-register unit: owns eip/ebp/esp and sequences byte-wide stack transfers.
// Optional overflow check enabled by defining STACK_ENGINE_OVF_CHECK_EN.
module stack_engine #(
  parameter logic [31:0] RESET_EIP   = 32'h0000_0000,
  parameter logic [31:0] RESET_ESP   = 32'h0000_1000,
  parameter logic [31:0] STACK_LIMIT = 32'h0000_0800
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  output logic [31:0] pop_data,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] eip,
  output logic [31:0] ebp,
  output logic [31:0] esp,
  output logic [3:0]  select_1,
  output logic        stack_fault
);

  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpPush  = 3'd1;
  localparam logic [2:0] OpPop   = 3'd2;
  localparam logic [2:0] OpCall  = 3'd3;
  localparam logic [2:0] OpRet   = 3'd4;
  localparam logic [2:0] OpEnter = 3'd5;
  localparam logic [2:0] OpLeave = 3'd6;
  localparam logic [2:0] OpJmp   = 3'd7;

  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] data_q, data_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [23:0] rbuf_q, rbuf_d;
  logic [31:0] eip_q, eip_d;
  logic [31:0] ebp_q, ebp_d;
  logic [31:0] esp_q, esp_d;
  logic [31:0] pop_q, pop_d;
  logic [31:0] rd_word;
  logic        push_class;
  logic        drop;

  // The final byte is taken straight off the bus in the last read cycle.
  assign rd_word    = {mem_rdata, rbuf_q};
  assign push_class = (cmd_op == OpPush) || (cmd_op == OpCall) || (cmd_op == OpEnter);

`ifdef STACK_ENGINE_OVF_CHECK_EN
  logic fault_q;

  assign drop = (esp_q - 32'd4) < STACK_LIMIT;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_q <= 1'b0;
    end else if (state_q == StIdle && cmd_valid && push_class && drop) begin
      fault_q <= 1'b1;
    end
  end

  assign stack_fault = fault_q;
`else
  assign drop        = 1'b0;
  assign stack_fault = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    data_d  = data_q;
    wbuf_d  = wbuf_q;
    rbuf_d  = rbuf_q;
    eip_d   = eip_q;
    ebp_d   = ebp_q;
    esp_d   = esp_q;
    pop_d   = pop_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          cnt_d  = 3'd0;
          unique case (cmd_op)
            OpJmp: eip_d = cmd_data;
            OpPush, OpCall, OpEnter: begin
              if (!(push_class && drop)) begin
                esp_d   = esp_q - 32'd4;
                state_d = StWrite;
                if (cmd_op == OpPush) begin
                  wbuf_d = cmd_data;
                end else if (cmd_op == OpCall) begin
                  wbuf_d = eip_q;
                end else begin
                  wbuf_d = ebp_q;
                end
              end
            end
            OpPop, OpRet: state_d = StRead;
            OpLeave: begin
              esp_d   = ebp_q;
              state_d = StRead;
            end
            default: ;
          endcase
        end
      end
      StWrite: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd3) begin
          state_d = StIdle;
          cnt_d   = 3'd0;
          if (op_q == OpCall) begin
            eip_d = data_q;
          end
          if (op_q == OpEnter) begin
            ebp_d = esp_q;
          end
        end
      end
      StRead: begin
        cnt_d = cnt_q + 3'd1;
        // Read data trails the strobe by one cycle, so byte k lands in cycle k+1.
        unique case (cnt_q)
          3'd1: rbuf_d[7:0]   = mem_rdata;
          3'd2: rbuf_d[15:8]  = mem_rdata;
          3'd3: rbuf_d[23:16] = mem_rdata;
          3'd4: begin
            esp_d   = esp_q + 32'd4;
            state_d = StIdle;
            cnt_d   = 3'd0;
            if (op_q == OpPop) begin
              pop_d = rd_word;
            end else if (op_q == OpRet) begin
              eip_d = rd_word;
            end else if (op_q == OpLeave) begin
              ebp_d = rd_word;
            end
          end
          default: ;
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      op_q    <= OpNop;
      data_q  <= 32'd0;
      wbuf_q  <= 32'd0;
      rbuf_q  <= 24'd0;
      eip_q   <= RESET_EIP;
      ebp_q   <= RESET_ESP;
      esp_q   <= RESET_ESP;
      pop_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      data_q  <= data_d;
      wbuf_q  <= wbuf_d;
      rbuf_q  <= rbuf_d;
      eip_q   <= eip_d;
      ebp_q   <= ebp_d;
      esp_q   <= esp_d;
      pop_q   <= pop_d;
    end
  end

  always_comb begin
    cmd_ready = (state_q == StIdle);
    select_1  = (state_q == StIdle) ? 4'h3 : 4'h2;
    mem_we    = (state_q == StWrite);
    mem_re    = (state_q == StRead) && (cnt_q != 3'd4);
    mem_addr  = 32'd0;
    mem_wdata = 8'd0;
    if (mem_we || mem_re) begin
      mem_addr = esp_q + {29'd0, cnt_q};
    end
    if (mem_we) begin
      unique case (cnt_q[1:0])
        2'd0: mem_wdata = wbuf_q[7:0];
        2'd1: mem_wdata = wbuf_q[15:8];
        2'd2: mem_wdata = wbuf_q[23:16];
        2'd3: mem_wdata = wbuf_q[31:24];
        default: mem_wdata = 8'd0;
      endcase
    end
  end

  assign pop_data = pop_q;
  assign eip      = eip_q;
  assign ebp      = ebp_q;
  assign esp      = esp_q;

endmodule

// File: tb/tb_stack_engine.sv
// Bench for stack_engine: directed steps then random commands against a word-level stack model.
module tb_stack_engine;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, CALL = 3'd3;
  localparam logic [2:0] RET = 3'd4, ENTER = 3'd5, LEAVE = 3'd6, JMP = 3'd7;
  localparam logic [31:0] LIMIT = 32'h0000_0800;

  logic        clk, reset_n, cmd_valid, cmd_ready, mem_we, mem_re, stack_fault;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data, pop_data, mem_addr, eip, ebp, esp;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [3:0]  select_1;

  stack_engine dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .pop_data   (pop_data),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .eip        (eip),
    .ebp        (ebp),
    .esp        (esp),
    .select_1   (select_1),
    .stack_fault(stack_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Byte memory seen by the DUT, and the model's expected copy.
  logic [7:0] mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] = mem_wdata;
    if (mem_re) mem_rdata <= mem_rd(mem_addr);
  end

  int we_cnt = 0, re_cnt = 0, both_cnt = 0, idle_strobe = 0, sel_bad = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_we) we_cnt++;
      if (mem_re) re_cnt++;
      if (mem_we && mem_re) both_cnt++;
      if (cmd_ready && (mem_we || mem_re)) idle_strobe++;
      if (select_1 !== (cmd_ready ? 4'h3 : 4'h2)) sel_bad++;
    end
  end

  logic [31:0] m_eip, m_ebp, m_esp, m_pop;
  logic        m_fault;

  task automatic model_reset();
    m_eip = 32'h0; m_ebp = 32'h1000; m_esp = 32'h1000; m_pop = 32'h0; m_fault = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "/eip"}, eip, m_eip);
    chk({tag, "/ebp"}, ebp, m_ebp);
    chk({tag, "/esp"}, esp, m_esp);
    chk({tag, "/pop_data"}, pop_data, m_pop);
    chk({tag, "/fault"}, {31'd0, stack_fault}, {31'd0, m_fault});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Run one command; the model decides the outcome from the stack rules alone.
  task automatic exec(input logic [2:0] op, input logic [31:0] d);
    int cyc, exp_lat, exp_we, exp_re;
    logic dropped, wrote;
    logic [31:0] val, nsp, base;
    string tag;
    tag = $sformatf("op%0d", op);
    exp_lat = 0; exp_we = 0; exp_re = 0; dropped = 1'b0; wrote = 1'b0;
    val = 32'h0; nsp = m_esp - 32'd4;
    case (op)
      JMP: m_eip = d;
      PUSH, CALL, ENTER: begin
`ifdef STACK_ENGINE_OVF_CHECK_EN
        dropped = (nsp < LIMIT);
`endif
        if (dropped) begin
          m_fault = 1'b1;
        end else begin
          val = (op == PUSH) ? d : (op == CALL) ? m_eip : m_ebp;
          for (int k = 0; k < 4; k++) ref_mem[nsp + k] = val[8*k +: 8];
          m_esp = nsp;
          if (op == CALL) m_eip = d;
          if (op == ENTER) m_ebp = nsp;
          exp_lat = 4; exp_we = 4; wrote = 1'b1;
        end
      end
      POP, RET, LEAVE: begin
        base = (op == LEAVE) ? m_ebp : m_esp;
        for (int k = 0; k < 4; k++) val[8*k +: 8] = ref_rd(base + k);
        m_esp = base + 32'd4;
        if (op == POP) m_pop = val;
        else if (op == RET) m_eip = val;
        else m_ebp = val;
        exp_lat = 5; exp_re = 4;
      end
      default: ;
    endcase
    @(negedge clk);
    we_cnt = 0; re_cnt = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = NOP;
    cyc = 0;
    while (!cmd_ready && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "/latency"}, cyc, exp_lat);
    chk({tag, "/we_cycles"}, we_cnt, exp_we);
    chk({tag, "/re_cycles"}, re_cnt, exp_re);
    chk_regs(tag);
    if (wrote) begin
      for (int k = 0; k < 4; k++) chk({tag, "/mem"}, {24'd0, mem_rd(nsp + k)}, {24'd0, val[8*k +: 8]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = NOP; cmd_data = 32'h0;
    model_reset();
    #12;
    chk("rst/eip", eip, 32'h0);
    chk("rst/ebp", ebp, 32'h1000);
    chk("rst/esp", esp, 32'h1000);
    chk("rst/pop_data", pop_data, 32'h0);
    chk("rst/mem_addr", mem_addr, 32'h0);
    chk("rst/mem_wdata", {24'd0, mem_wdata}, 32'h0);
    chk("rst/strobes", {30'd0, mem_we, mem_re}, 32'h0);
    chk("rst/cmd_ready", {31'd0, cmd_ready}, 32'h1);
    chk("rst/select_1", {28'd0, select_1}, 32'h3);
    chk("rst/fault", {31'd0, stack_fault}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    exec(PUSH, 32'hDEAD_BEEF);
    chk("push1/esp", esp, 32'h0FFC);
    chk("push1/b0", {24'd0, mem_rd(32'h0FFC)}, 32'hEF);
    chk("push1/b3", {24'd0, mem_rd(32'h0FFF)}, 32'hDE);

    do_reset();
    exec(PUSH, 32'h1122_3344);
    exec(POP, 32'h0);
    chk("pop/pop_data", pop_data, 32'h1122_3344);
    chk("pop/esp", esp, 32'h1000);

    do_reset();
    exec(JMP, 32'h40);
    exec(CALL, 32'h200);
    chk("call/eip", eip, 32'h200);
    chk("call/ret_addr", {24'd0, mem_rd(32'h0FFC)}, 32'h40);
    exec(RET, 32'h0);
    chk("ret/eip", eip, 32'h40);

    do_reset();
    exec(ENTER, 32'h0);
    chk("enter/ebp", ebp, 32'h0FFC);
    chk("enter/esp", esp, 32'h0FFC);
    exec(LEAVE, 32'h0);
    chk("leave/ebp", ebp, 32'h1000);
    chk("leave/esp", esp, 32'h1000);
    exec(JMP, 32'h80);
    chk("jmp/eip", eip, 32'h80);

    // Abort a PUSH of 32'hCAFEF00D during write cycle 2.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = PUSH; cmd_data = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = NOP;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    ref_mem[32'h0FFC] = 8'h0D;
    ref_mem[32'h0FFD] = 8'hF0;
    chk("abort/mem_we", {31'd0, mem_we}, 32'h0);
    chk("abort/mem_addr", mem_addr, 32'h0);
    chk("abort/cmd_ready", {31'd0, cmd_ready}, 32'h1);
    chk_regs("abort");
    for (int k = 0; k < 4; k++)
      chk("abort/mem", {24'd0, mem_rd(32'h0FFC + k)}, {24'd0, ref_rd(32'h0FFC + k)});
    @(negedge clk);
    reset_n = 1'b1;

    // Walk esp down to the limit through two LEAVEs of preloaded frame links.
    for (int k = 0; k < 4; k++) begin
      mem[32'h1000 + k] = 8'(32'h0000_07FC >> (8*k));
      ref_mem[32'h1000 + k] = 8'(32'h0000_07FC >> (8*k));
      mem[32'h07FC + k] = 8'(32'h1234_5678 >> (8*k));
      ref_mem[32'h07FC + k] = 8'(32'h1234_5678 >> (8*k));
    end
    exec(LEAVE, 32'h0);
    exec(LEAVE, 32'h0);
    chk("ovf/esp_at_limit", esp, 32'h0800);
    exec(PUSH, 32'hAAAA_5555);
`ifdef STACK_ENGINE_OVF_CHECK_EN
    chk("ovf/esp_kept", esp, 32'h0800);
    chk("ovf/fault", {31'd0, stack_fault}, 32'h1);
`else
    chk("ovf/esp_pushed", esp, 32'h07FC);
    chk("ovf/b0", {24'd0, mem_rd(32'h07FC)}, 32'h55);
`endif

    do_reset();
    for (int i = 0; i < 80; i++) begin
      exec(3'($urandom_range(0, 7)), $urandom);
    end

    chk("never_both_strobes", both_cnt, 0);
    chk("idle_strobes", idle_strobe, 0);
    chk("select_1_tracking", sel_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
